// File: rtl/ps2_scancode_rx_if.sv
// Pin-side and scancode-side signals of the PS/2 receiver, bundled so the
// keyboard controller and the receiver share one port.
interface ps2_scancode_rx_if;
  logic       ps2_clock;
  logic       ps2_data;
  logic [7:0] scancode;
  logic       valid;
  logic       parity_err;
  logic       frame_err;
  logic       busy;

  // master drives the raw pins and consumes scancodes; slave is the receiver
  modport master (
    output ps2_clock, ps2_data,
    input  scancode, valid, parity_err, frame_err, busy
  );

  modport slave (
    input  ps2_clock, ps2_data,
    output scancode, valid, parity_err, frame_err, busy
  );
endinterface

// File: rtl/ps2_scancode_rx.sv
// PS/2 device-to-host receiver: pin synchronisers, clock glitch filter,
// 11-bit frame capture with odd-parity/stop checking and inter-edge timeout.
module ps2_scancode_rx #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input logic              clk_in,
  input logic              reset_n,
  ps2_scancode_rx_if.slave bus
);

  localparam int CNT_W = $clog2(FILTER_LEN + 1);
  localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

  logic [1:0]       r_clk_sync;
  logic [1:0]       r_dat_sync;
  logic             w_clk_s;
  logic             w_dat_s;
  logic             r_filt_lvl;
  logic             r_filt_prev;
  logic [CNT_W-1:0] r_filt_cnt;
  logic             w_fall;
  logic             r_fall;

  state_t           r_state;
  logic [7:0]       r_shift;
  logic [2:0]       r_idx;
  logic             r_par;
  logic [7:0]       r_scancode;
  logic             r_valid;
  logic             r_perr;
  logic             r_ferr;
  logic [TO_W-1:0]  r_to_cnt;
  logic             w_par_ok;

  assign w_clk_s = r_clk_sync[1];
  assign w_dat_s = r_dat_sync[1];

  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      r_clk_sync <= 2'b11;
      r_dat_sync <= 2'b11;
    end else begin
      r_clk_sync <= {r_clk_sync[0], bus.ps2_clock};
      r_dat_sync <= {r_dat_sync[0], bus.ps2_data};
    end
  end

  // Level flips only after FILTER_LEN consecutive disagreeing samples.
  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      r_filt_lvl  <= 1'b1;
      r_filt_prev <= 1'b1;
      r_filt_cnt  <= '0;
      r_fall      <= 1'b0;
    end else begin
      r_filt_prev <= r_filt_lvl;
      r_fall      <= w_fall;
      if (w_clk_s == r_filt_lvl) begin
        r_filt_cnt <= '0;
      end else if (r_filt_cnt == CNT_W'(FILTER_LEN - 1)) begin
        r_filt_lvl <= w_clk_s;
        r_filt_cnt <= '0;
      end else begin
        r_filt_cnt <= r_filt_cnt + 1'b1;
      end
    end
  end

  assign w_fall   = r_filt_prev & ~r_filt_lvl;
  assign w_par_ok = ^{r_shift, r_par};

  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= S_IDLE;
      r_shift    <= '0;
      r_idx      <= '0;
      r_par      <= 1'b0;
      r_scancode <= '0;
      r_valid    <= 1'b0;
      r_perr     <= 1'b0;
      r_ferr     <= 1'b0;
      r_to_cnt   <= '0;
    end else begin
      r_valid <= 1'b0;
      r_perr  <= 1'b0;
      r_ferr  <= 1'b0;
      // An edge arriving on the expiry cycle is processed instead of timing out.
      if (r_fall) begin
        r_to_cnt <= '0;
        case (r_state)
          S_IDLE: begin
            if (!w_dat_s) begin
              r_state <= S_DATA;
              r_idx   <= '0;
            end
          end
          S_DATA: begin
            r_shift[r_idx] <= w_dat_s;
            if (r_idx == 3'd7) r_state <= S_PARITY;
            else               r_idx   <= r_idx + 3'd1;
          end
          S_PARITY: begin
            r_par   <= w_dat_s;
            r_state <= S_STOP;
          end
          S_STOP: begin
            if (!w_dat_s) begin
              r_ferr <= 1'b1;
            end else if (w_par_ok) begin
              r_scancode <= r_shift;
              r_valid    <= 1'b1;
            end else begin
              r_perr <= 1'b1;
            end
            r_state <= S_IDLE;
          end
          default: r_state <= S_IDLE;
        endcase
      end else if (r_state != S_IDLE) begin
        if (r_to_cnt == TO_W'(TIMEOUT_CYCLES - 1)) begin
          r_state  <= S_IDLE;
          r_ferr   <= 1'b1;
          r_to_cnt <= '0;
        end else begin
          r_to_cnt <= r_to_cnt + 1'b1;
        end
      end else begin
        r_to_cnt <= '0;
      end
    end
  end

  assign bus.scancode   = r_scancode;
  assign bus.valid      = r_valid;
  assign bus.parity_err = r_perr;
  assign bus.frame_err  = r_ferr;
  assign bus.busy       = (r_state != S_IDLE);

endmodule

// File: tb/tb_ps2_scancode_rx.sv
// Scoreboard bench for ps2_scancode_rx: frames are driven on the pins, the
// expected pulse (kind, scancode, cycle) is queued and matched by a monitor.
module tb_ps2_scancode_rx;

  localparam int FL   = 8;
  localparam int TO   = 500;
  localparam int HALF = 20;
  localparam int LAT  = FL + 3;

  localparam int K_VALID = 0;
  localparam int K_PERR  = 1;
  localparam int K_FERR  = 2;

  typedef struct {
    int         kind;
    logic [7:0] sc;
    longint     t;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  longint     cyc = 0;
  int         errors = 0;
  int         checks = 0;
  logic [7:0] last_sc = 8'h00;
  exp_t       sb[$];

  ps2_scancode_rx_if ifc ();

  ps2_scancode_rx #(.FILTER_LEN(FL), .TIMEOUT_CYCLES(TO)) dut (
    .clk_in  (clk),
    .reset_n (rst_n),
    .bus     (ifc)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, pending=%0d", sb.size());
    $fatal(1, "watchdog expired");
  end

  // Monitor: every output pulse must match the head of the scoreboard.
  always @(negedge clk) begin : mon
    exp_t e;
    int   k;
    if (rst_n && (ifc.valid || ifc.parity_err || ifc.frame_err)) begin
      k = ifc.valid ? K_VALID : (ifc.parity_err ? K_PERR : K_FERR);
      checks++;
      if ((32'(ifc.valid) + 32'(ifc.parity_err) + 32'(ifc.frame_err)) != 1) begin
        errors++;
        $display("FAIL exclusive: valid=%b parity_err=%b frame_err=%b, required one-hot",
                 ifc.valid, ifc.parity_err, ifc.frame_err);
      end else if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_pulse: kind=%0d at cycle %0d, required none", k, cyc);
      end else begin
        e = sb.pop_front();
        if (k !== e.kind) begin
          errors++;
          $display("FAIL pulse_kind: got %0d, required %0d", k, e.kind);
        end
        checks++;
        if (ifc.scancode !== e.sc) begin
          errors++;
          $display("FAIL pulse_scancode: got %02h, required %02h", ifc.scancode, e.sc);
        end
        checks++;
        if (cyc !== e.t) begin
          errors++;
          $display("FAIL pulse_time: got cycle %0d, required %0d", cyc, e.t);
        end
        $display("pulse kind=%0d scancode=%02h cycle=%0d", k, ifc.scancode, cyc);
      end
    end
  end

  task automatic clk_fall(input logic b, input bit glitch, output longint t);
    @(negedge clk);
    ifc.ps2_data = b;
    repeat (HALF / 2) @(negedge clk);
    if (glitch) begin
      ifc.ps2_clock = 1'b0;
      repeat (3) @(negedge clk);
      ifc.ps2_clock = 1'b1;
    end
    repeat (HALF / 2) @(negedge clk);
    ifc.ps2_clock = 1'b0;
    t = cyc + 1;
  endtask

  task automatic clk_rise();
    repeat (HALF) @(negedge clk);
    ifc.ps2_clock = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] d, input bit bad_par, input logic stop,
                            input bit glitch);
    logic [10:0] bits;
    longint      t;
    exp_t        e;
    bits = {stop, (~^d) ^ bad_par, d, 1'b0};
    for (int i = 0; i < 11; i++) begin
      clk_fall(bits[i], glitch && (i > 0), t);
      if (i == 10) begin
        e.t = t + LAT;
        if (!stop) begin
          e.kind = K_FERR;
          e.sc   = last_sc;
        end else if (bad_par) begin
          e.kind = K_PERR;
          e.sc   = last_sc;
        end else begin
          e.kind  = K_VALID;
          e.sc    = d;
          last_sc = d;
        end
        sb.push_back(e);
      end
      clk_rise();
    end
    ifc.ps2_data = 1'b1;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 400 && sb.size() != 0; i++) @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    ifc.ps2_clock = 1'b1;
    ifc.ps2_data  = 1'b1;
    repeat (4) @(negedge clk);
    checks++;
    if (ifc.scancode !== 8'h00 || ifc.busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: scancode=%02h busy=%b, required 00/0", ifc.scancode, ifc.busy);
    end
    checks++;
    if ({ifc.valid, ifc.parity_err, ifc.frame_err} !== 3'b000) begin
      errors++;
      $display("FAIL reset_pulses: got %b, required 000",
               {ifc.valid, ifc.parity_err, ifc.frame_err});
    end
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    $display("test_reset done");
  endtask

  task automatic test_good_frames();
    send_frame(8'h1C, 1'b0, 1'b1, 1'b0);
    send_frame(8'hF0, 1'b0, 1'b1, 1'b0);
    send_frame(8'h1C, 1'b0, 1'b1, 1'b0);
    wait_drain();
    checks++;
    if (sb.size() !== 0) begin
      errors++;
      $display("FAIL good_frames_drain: pending=%0d, required 0", sb.size());
    end
    checks++;
    if (ifc.scancode !== 8'h1C) begin
      errors++;
      $display("FAIL good_frames_scancode: got %02h, required 1c", ifc.scancode);
    end
    $display("test_good_frames done");
  endtask

  task automatic test_bad_parity();
    send_frame(8'h29, 1'b1, 1'b1, 1'b0);
    wait_drain();
    checks++;
    if (ifc.scancode !== 8'h1C) begin
      errors++;
      $display("FAIL bad_parity_hold: got %02h, required 1c", ifc.scancode);
    end
    send_frame(8'h5A, 1'b0, 1'b1, 1'b0);
    wait_drain();
    checks++;
    if (sb.size() !== 0 || ifc.scancode !== 8'h5A) begin
      errors++;
      $display("FAIL bad_parity_recover: scancode=%02h pending=%0d, required 5a/0",
               ifc.scancode, sb.size());
    end
    $display("test_bad_parity done");
  endtask

  task automatic test_bad_stop();
    send_frame(8'h45, 1'b0, 1'b0, 1'b0);
    wait_drain();
    checks++;
    if (sb.size() !== 0 || ifc.busy !== 1'b0) begin
      errors++;
      $display("FAIL bad_stop: busy=%b pending=%0d, required 0/0", ifc.busy, sb.size());
    end
    checks++;
    if (ifc.scancode !== 8'h5A) begin
      errors++;
      $display("FAIL bad_stop_hold: got %02h, required 5a", ifc.scancode);
    end
    $display("test_bad_stop done");
  endtask

  task automatic test_timeout();
    logic [5:0] bits;
    longint     t;
    exp_t       e;
    bits = 6'b10011_0;
    for (int i = 0; i < 6; i++) begin
      clk_fall(bits[i], 1'b0, t);
      if (i == 5) begin
        e.kind = K_FERR;
        e.sc   = last_sc;
        e.t    = t + LAT + TO;
        sb.push_back(e);
      end
      clk_rise();
    end
    ifc.ps2_data = 1'b1;
    checks++;
    if (ifc.busy !== 1'b1) begin
      errors++;
      $display("FAIL timeout_busy: got %b, required 1", ifc.busy);
    end
    repeat (TO + 100) @(negedge clk);
    checks++;
    if (sb.size() !== 0 || ifc.busy !== 1'b0) begin
      errors++;
      $display("FAIL timeout_expire: busy=%b pending=%0d, required 0/0", ifc.busy, sb.size());
    end
    send_frame(8'h16, 1'b0, 1'b1, 1'b0);
    wait_drain();
    checks++;
    if (ifc.scancode !== 8'h16) begin
      errors++;
      $display("FAIL timeout_recover: got %02h, required 16", ifc.scancode);
    end
    $display("test_timeout done");
  endtask

  task automatic test_glitch();
    bit busy_seen;
    send_frame(8'h4D, 1'b0, 1'b1, 1'b1);
    wait_drain();
    checks++;
    if (sb.size() !== 0 || ifc.scancode !== 8'h4D) begin
      errors++;
      $display("FAIL glitch_frame: scancode=%02h pending=%0d, required 4d/0",
               ifc.scancode, sb.size());
    end
    @(negedge clk);
    ifc.ps2_data = 1'b0;
    repeat (5) @(negedge clk);
    ifc.ps2_clock = 1'b0;
    repeat (3) @(negedge clk);
    ifc.ps2_clock = 1'b1;
    busy_seen = 1'b0;
    repeat (30) begin
      @(negedge clk);
      if (ifc.busy !== 1'b0) busy_seen = 1'b1;
    end
    checks++;
    if (busy_seen) begin
      errors++;
      $display("FAIL idle_glitch_busy: got 1, required 0");
    end
    ifc.ps2_data = 1'b1;
    repeat (5) @(negedge clk);
    $display("test_glitch done");
  endtask

  task automatic test_async_reset();
    logic [3:0] bits;
    longint     t;
    bits = 4'b101_0;
    for (int i = 0; i < 4; i++) begin
      clk_fall(bits[i], 1'b0, t);
      clk_rise();
    end
    checks++;
    if (ifc.busy !== 1'b1) begin
      errors++;
      $display("FAIL async_reset_pre_busy: got %b, required 1", ifc.busy);
    end
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (ifc.scancode !== 8'h00 || ifc.busy !== 1'b0) begin
      errors++;
      $display("FAIL async_reset_state: scancode=%02h busy=%b, required 00/0",
               ifc.scancode, ifc.busy);
    end
    checks++;
    if ({ifc.valid, ifc.parity_err, ifc.frame_err} !== 3'b000) begin
      errors++;
      $display("FAIL async_reset_pulses: got %b, required 000",
               {ifc.valid, ifc.parity_err, ifc.frame_err});
    end
    ifc.ps2_clock = 1'b1;
    ifc.ps2_data  = 1'b1;
    last_sc = 8'h00;
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    send_frame(8'h1C, 1'b0, 1'b1, 1'b0);
    wait_drain();
    checks++;
    if (sb.size() !== 0 || ifc.scancode !== 8'h1C) begin
      errors++;
      $display("FAIL async_reset_recover: scancode=%02h pending=%0d, required 1c/0",
               ifc.scancode, sb.size());
    end
    $display("test_async_reset done");
  endtask

  initial begin
    ifc.ps2_clock = 1'b1;
    ifc.ps2_data  = 1'b1;
    test_reset();
    test_good_frames();
    test_bad_parity();
    test_bad_stop();
    test_timeout();
    test_glitch();
    test_async_reset();
    repeat (20) @(negedge clk);
    checks++;
    if (sb.size() !== 0) begin
      errors++;
      $display("FAIL final_drain: pending=%0d, required 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ps2_scancode_rx.md
# ps2_scancode_rx

PS/2 device-to-host receiver that turns the raw `ps2_clock`/`ps2_data` pin pair into one-cycle-valid 8-bit scancodes. It sits directly upstream of the keyboard controller and feeds its `scancode`/`valid` inputs. Break prefixes (F0) are passed through as ordinary bytes. The block does pin synchronisation, clock glitch filtering, 11-bit frame capture, parity/stop checking and inter-edge timeout recovery.

## Interface
- `FILTER_LEN`, 8: consecutive equal synchronised `ps2_clock` samples required to change the filtered clock level (2..16).
- `TIMEOUT_CYCLES`, 50000: `clk_in` cycles without a filtered falling edge before a partial frame is dropped (1 ms at 50 MHz).
- `clk_in` input 1: system clock, 50 MHz, all logic on its rising edge.
- `reset_n` input 1: asynchronous, active-low reset.
- `ps2_clock` input 1: raw PS/2 clock pin, asynchronous.
- `ps2_data` input 1: raw PS/2 data pin, asynchronous.
- `scancode` output 8: last correctly received byte; holds between frames.
- `valid` output 1: one-cycle pulse, `scancode` is new this cycle.
- `parity_err` output 1: one-cycle pulse, frame dropped on odd-parity failure.
- `frame_err` output 1: one-cycle pulse, frame dropped on bad stop bit or timeout.
- `busy` output 1: high while a frame is in progress (state ≠ IDLE).

## Operation
- Reset (`reset_n` low, any time): `scancode`=0x00, `valid`=0, `parity_err`=0, `frame_err`=0, `busy`=0. Sync flops, filtered clock, and filter state go to 1. FSM goes to IDLE. Timeout counter=0. Shift register=0. A frame in progress is discarded and produces no output pulse.
- Synchronisation: each pin passes through a 2-flop synchroniser. The data bit is always sampled from the synchronised `ps2_data`.
- Filter: a saturating counter counts consecutive synchronised `ps2_clock` samples that differ from the filtered level. The filtered level flips when the count reaches `FILTER_LEN`. Any matching sample clears the count. A falling edge is the cycle the filtered level goes from 1 to 0.
- FSM, advanced only on a falling edge:
  - IDLE: data=0 (start bit) → DATA, bit index=0. Data=1 → stay IDLE, no error.
  - DATA: shift the data bit into bit[index], LSB first. After the 8th bit → PARITY.
  - PARITY: store the bit, then → STOP.
  - STOP:
    - Stop bit=1 and XOR of the 8 data bits plus parity = 1 (odd parity): load `scancode`, pulse `valid`.
    - Stop bit=1 and parity wrong: pulse `parity_err`, `scancode` unchanged.
    - Stop bit=0: pulse `frame_err` (takes priority over a parity check). `scancode` unchanged.
    - Always → IDLE.
- Timeout: the counter runs when state ≠ IDLE and clears on every falling edge and in IDLE. When it reaches `TIMEOUT_CYCLES`, the FSM goes to IDLE and `frame_err` pulses.
  - A falling edge in the same cycle the counter would expire wins: no timeout, the edge is processed.
- Only one of `valid`/`parity_err`/`frame_err` is high in any cycle.
- Host-to-device transmission is not supported. Both pins are input-only.

## Timing
- An edge on the `ps2_clock` pin is seen by the filter 2 cycles later. The filtered fall occurs `FILTER_LEN` cycles after the first low synchronised sample.
- `valid`/error outputs are registered and assert on the cycle after the filtered fall of the stop-bit clock. Total latency from the first `clk_in` edge that samples the stop-bit clock pin low is `FILTER_LEN`+3 cycles (11 with defaults).
- Pulse width is exactly 1 cycle. `scancode` changes on the same edge `valid` rises.
- Data must be stable at the pin at least 3 cycles before the clock pin falls. This is always met by PS/2 (≥5 µs setup).
- A `ps2_clock` glitch shorter than `FILTER_LEN` cycles produces no edge.
- `busy` rises the cycle after the start-bit edge. It falls the cycle after the STOP edge or the timeout expiry.
- Back-to-back frames need no gap beyond the PS/2 idle-high stop bit.

## Test plan
- Reset: drive `reset_n` low mid-run → all outputs 0 and `scancode`=0x00 immediately (asynchronous). Release, then send frame 0x1C → exactly one `valid`, `scancode`=0x1C.
- Good frames at a 12.5 kHz PS/2 clock: send 0x1C (parity 0), then F0, then 1C → three `valid` pulses carrying 0x1C, 0xF0, 0x1C. Each pulse comes 11 cycles after the stop-bit clock fall. No error pulses.
- Bad parity: send 0x29 with parity bit 1 → one `parity_err` pulse, no `valid`, `scancode` keeps the previous value. The next good 0x5A gives `valid`, `scancode`=0x5A.
- Bad stop: send 0x45 with stop bit 0 → one `frame_err` pulse, no `valid`, `busy` drops.
- Timeout: send start + 5 data bits, then hold the clock high 60000 cycles → `frame_err` exactly 50000 cycles after the last filtered fall. A following 0x16 frame yields `scancode`=0x16.
- Glitch immunity:
  - Insert 3-cycle low pulses on `ps2_clock` between bits of frame 0x4D → `scancode`=0x4D, no errors.
  - A 3-cycle low pulse in IDLE with data=0 → `busy` stays 0.
